ysyx_23060240_axi_rr_arb: RTL and testbench
===========================================

# ysyx_23060240_axi_rr_arb

Two-master AXI4-Lite arbiter that shares one downstream AXI4-Lite port between the instruction-fetch master (IFU, read-only) and the load/store master (LSU, read+write). It sits between the core masters and the address decoder/crossbar. It issues registered, round-robin grants. Each grant is held until the transaction's response handshake completes, and only one transaction is outstanding at a time.

## Interface
- No parameters; address and data widths are fixed at 32.
- `clk`  in  1  system clock
- `rst`  in  1  reset, asynchronous, active-low
- `ifu_araddr`/`ifu_arvalid`/`ifu_arready`  in/in/out  32/1/1  IFU read address channel
- `ifu_rdata`/`ifu_rvalid`/`ifu_rready`  out/out/in  32/1/1  IFU read data channel
- `lsu_araddr`/`lsu_arvalid`/`lsu_arready`  in/in/out  32/1/1  LSU read address channel
- `lsu_rdata`/`lsu_rvalid`/`lsu_rready`  out/out/in  32/1/1  LSU read data channel
- `lsu_awaddr`/`lsu_awvalid`/`lsu_awready`  in/in/out  32/1/1  LSU write address channel
- `lsu_wdata`/`lsu_wstrb`/`lsu_wvalid`/`lsu_wready`  in/in/in/out  32/4/1/1  LSU write data channel
- `lsu_bvalid`/`lsu_bready`  out/in  1/1  LSU write response channel
- `m_araddr, m_arvalid, m_arready, m_rdata, m_rvalid, m_rready, m_awaddr, m_awvalid, m_awready, m_wdata, m_wstrb, m_wvalid, m_wready, m_bvalid, m_bready`  downstream port; directions mirror the above, with the arbiter acting as master

## Operation
- **States:**
  - IDLE
  - RD_IFU
  - RD_LSU
  - WR_LSU
- **Request terms:**
  - r_ifu = `ifu_arvalid`
  - r_lrd = `lsu_arvalid`
  - r_lwr = `lsu_awvalid | lsu_wvalid`
- **LSU internal priority:** r_lrd beats r_lwr. The LSU request is (r_lrd | r_lwr).
- **Round-robin:** a `last` register records the owner of the most recent grant and resets to LSU. When IFU and LSU both request in IDLE, the master not equal to `last` wins. A single requester always wins. `last` updates on every grant.
- **IDLE:**
  - All downstream valids/readies are 0.
  - All upstream readies/valids are 0.
  - All forwarded addr/data/strb are 0.
- **RD_x:** combinational pass-through between the owner and the downstream port.
  - Forward AR and R: `m_araddr/m_arvalid` ← owner; owner `arready` ← `m_arready`; owner `rvalid/rdata` ← `m_rvalid/m_rdata`; `m_rready` ← owner `rready`.
  - The non-owner sees `arready=rvalid=0` and `rdata=0`.
- **WR_LSU:**
  - AW, W and B pass through.
  - Flags `aw_done`/`w_done` are set on the respective handshakes and cleared on entering WR_LSU.
  - `m_awvalid = lsu_awvalid & ~aw_done`; likewise for W.
  - `m_bready = lsu_bready`.
- **Release:**
  - RD_x → IDLE on the cycle `m_rvalid & m_rready`.
  - WR_LSU → IDLE on the cycle `m_bvalid & m_bready`.
- **Ignored traffic:**
  - A requester that drops valid while not granted is simply not served.
  - Write channels from a non-granted LSU are ignored; their readies are held 0.
- **Out-of-sequence responses:** a B or R arriving in the wrong state is not forwarded and not acknowledged.

## Timing
- **Grant latency:** a request seen in IDLE at edge N leads to the grant state at N+1, with the downstream valid visible in the cycle after edge N+1. Minimum latency is 1 cycle.
- **Response-to-next-grant:** the response handshake at edge N moves the FSM to IDLE at N+1. The next grant is at N+2, giving a 1 idle cycle gap between transactions.
- **Grant stability:** the grant never changes while a transaction is in progress, regardless of new requests.
- **AW/W ordering:** AW and W may handshake in either order or in the same cycle. B is forwarded only through `lsu_bvalid`; it is not gated by the flags.
- **Reset:**
  - Asserting `rst` low at any time, including mid-transaction, asynchronously forces IDLE, `last`=LSU and `aw_done=w_done=0`.
  - All outputs go to 0 immediately.
  - The in-flight downstream response is dropped.

## Structure
- **Package `ysyx_23060240_arb_pkg`:**
  - State enum: IDLE=2'd0, RD_IFU=2'd1, RD_LSU=2'd2, WR_LSU=2'd3.
  - Owner encoding: OWN_IFU=1'b0, OWN_LSU=1'b1.
- **Sub-module `ysyx_23060240_rr_pick2`:**
  - Pure 2-way round-robin picker.
  - Inputs: `req[1:0]` and `last`.
  - Outputs: `gnt_valid` and `gnt_id`.
- The top module holds the FSM, `last`, the AW/W flags and the channel muxes.

## Test plan
- IFU read of `0x80000000` alone: IFU read → RD_IFU 1 cycle after `ifu_arvalid`. Slave returns `rdata=0x00000413` → `ifu_rdata=0x00000413` and `ifu_rvalid=1`. `lsu_rvalid` stays 0.
- Simultaneous IFU read and LSU read after reset → IFU is granted first. On release, with both still requesting, LSU is granted next. Then IFU again, alternating.
- LSU write `awaddr=0xa00003f8`, `wdata=0x41`, `wstrb=4'b0001` with W one cycle before AW → one `m_wvalid` pulse and one `m_awvalid` handshake, then `lsu_bvalid`. FSM reaches IDLE the cycle after the B handshake.
- LSU holds `lsu_arvalid` and `lsu_awvalid` together → the read is served first, then the write.
- Slave stalls `m_rvalid` 20 cycles while the LSU requests → the LSU gets no `arready`. The grant to IFU is held for the full stall.
- `rst` driven low mid-WR_LSU after the AW handshake → all outputs are 0 within the same cycle. After release, the next LSU write starts with both flags clear.

Source files
------------

// File: rtl/ysyx_23060240_arb_pkg.sv
// Shared definitions for the two-master AXI4-Lite round-robin arbiter.
//   arb_state_e : arbiter FSM states (idle, read for IFU, read for LSU, write for LSU)
//   OWN_IFU/OWN_LSU : owner encoding used by the picker and the `last` register
package ysyx_23060240_arb_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STRB_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RD_IFU = 2'd1,
    RD_LSU = 2'd2,
    WR_LSU = 2'd3
  } arb_state_e;

  localparam logic OWN_IFU = 1'b0;
  localparam logic OWN_LSU = 1'b1;

endpackage

// File: rtl/ysyx_23060240_rr_pick2.sv
// Pure combinational 2-way round-robin picker.
//   req[1:0]  : request vector, bit index equals owner id (0 = IFU, 1 = LSU)
//   last      : owner of the most recent grant
//   gnt_valid : at least one request is present
//   gnt_id    : chosen owner; on contention the one that is not `last`
module ysyx_23060240_rr_pick2
  import ysyx_23060240_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic       gnt_valid,
  output logic       gnt_id
);

  // choose a winner; a lone requester always wins
  always_comb begin
    gnt_valid = |req;
    gnt_id    = OWN_IFU;
    case (req)
      2'b01:   gnt_id = OWN_IFU;
      2'b10:   gnt_id = OWN_LSU;
      2'b11:   gnt_id = ~last;
      default: gnt_id = OWN_IFU;
    endcase
  end

endmodule

// File: rtl/ysyx_23060240_axi_rr_arb.sv
// Two-master AXI4-Lite arbiter: shares one downstream port between the IFU
// (read only) and the LSU (read + write). One transaction outstanding at a
// time; the grant is taken in IDLE and held until the R or B handshake.
//   clk, rst            : clock, asynchronous active-low reset
//   ifu_ar*/ifu_r*      : IFU read address / read data channels
//   lsu_ar*/lsu_r*      : LSU read address / read data channels
//   lsu_aw*/lsu_w*/lsu_b*: LSU write address / write data / write response
//   m_*                 : downstream port, arbiter acts as master
module ysyx_23060240_axi_rr_arb
  import ysyx_23060240_arb_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] ifu_araddr,
  input  logic              ifu_arvalid,
  output logic              ifu_arready,
  output logic [DATA_W-1:0] ifu_rdata,
  output logic              ifu_rvalid,
  input  logic              ifu_rready,
  input  logic [ADDR_W-1:0] lsu_araddr,
  input  logic              lsu_arvalid,
  output logic              lsu_arready,
  output logic [DATA_W-1:0] lsu_rdata,
  output logic              lsu_rvalid,
  input  logic              lsu_rready,
  input  logic [ADDR_W-1:0] lsu_awaddr,
  input  logic              lsu_awvalid,
  output logic              lsu_awready,
  input  logic [DATA_W-1:0] lsu_wdata,
  input  logic [STRB_W-1:0] lsu_wstrb,
  input  logic              lsu_wvalid,
  output logic              lsu_wready,
  output logic              lsu_bvalid,
  input  logic              lsu_bready,
  output logic [ADDR_W-1:0] m_araddr,
  output logic              m_arvalid,
  input  logic              m_arready,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic              m_rvalid,
  output logic              m_rready,
  output logic [ADDR_W-1:0] m_awaddr,
  output logic              m_awvalid,
  input  logic              m_awready,
  output logic [DATA_W-1:0] m_wdata,
  output logic [STRB_W-1:0] m_wstrb,
  output logic              m_wvalid,
  input  logic              m_wready,
  input  logic              m_bvalid,
  output logic              m_bready
);

  arb_state_e state;
  arb_state_e state_next;
  logic       last;
  logic       aw_done;
  logic       w_done;
  logic       r_lrd;
  logic       r_lwr;
  logic       gnt_valid;
  logic       gnt_id;

  assign r_lrd = lsu_arvalid;
  assign r_lwr = lsu_awvalid | lsu_wvalid;

  ysyx_23060240_rr_pick2 u_pick (
    .req       ({r_lrd | r_lwr, ifu_arvalid}),
    .last      (last),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id)
  );

  // state, round-robin history and write-channel completion flags
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      last    <= OWN_LSU;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      state <= state_next;
      if (state == IDLE && gnt_valid) begin
        last <= gnt_id;
      end else begin
        last <= last;
      end
      // flags only live inside WR_LSU, so they are clear on every entry
      if (state == WR_LSU) begin
        aw_done <= aw_done | (m_awvalid & m_awready);
        w_done  <= w_done | (m_wvalid & m_wready);
      end else begin
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end
    end
  end

  // next state and channel muxes; everything not owned stays at zero
  always_comb begin
    state_next  = state;
    ifu_arready = 1'b0;
    ifu_rdata   = 32'h0000_0000;
    ifu_rvalid  = 1'b0;
    lsu_arready = 1'b0;
    lsu_rdata   = 32'h0000_0000;
    lsu_rvalid  = 1'b0;
    lsu_awready = 1'b0;
    lsu_wready  = 1'b0;
    lsu_bvalid  = 1'b0;
    m_araddr    = 32'h0000_0000;
    m_arvalid   = 1'b0;
    m_rready    = 1'b0;
    m_awaddr    = 32'h0000_0000;
    m_awvalid   = 1'b0;
    m_wdata     = 32'h0000_0000;
    m_wstrb     = 4'b0000;
    m_wvalid    = 1'b0;
    m_bready    = 1'b0;
    case (state)
      IDLE: begin
        if (gnt_valid) begin
          if (gnt_id == OWN_IFU) begin
            state_next = RD_IFU;
          end else if (r_lrd) begin
            state_next = RD_LSU;
          end else begin
            state_next = WR_LSU;
          end
        end else begin
          state_next = IDLE;
        end
      end
      RD_IFU: begin
        m_araddr    = ifu_araddr;
        m_arvalid   = ifu_arvalid;
        ifu_arready = m_arready;
        ifu_rdata   = m_rdata;
        ifu_rvalid  = m_rvalid;
        m_rready    = ifu_rready;
        if (m_rvalid && ifu_rready) begin
          state_next = IDLE;
        end else begin
          state_next = RD_IFU;
        end
      end
      RD_LSU: begin
        m_araddr    = lsu_araddr;
        m_arvalid   = lsu_arvalid;
        lsu_arready = m_arready;
        lsu_rdata   = m_rdata;
        lsu_rvalid  = m_rvalid;
        m_rready    = lsu_rready;
        if (m_rvalid && lsu_rready) begin
          state_next = IDLE;
        end else begin
          state_next = RD_LSU;
        end
      end
      WR_LSU: begin
        m_awaddr    = lsu_awaddr;
        m_awvalid   = lsu_awvalid & ~aw_done;
        lsu_awready = m_awready & ~aw_done;
        m_wdata     = lsu_wdata;
        m_wstrb     = lsu_wstrb;
        m_wvalid    = lsu_wvalid & ~w_done;
        lsu_wready  = m_wready & ~w_done;
        // B is not gated by the flags: the slave decides when it responds
        lsu_bvalid  = m_bvalid;
        m_bready    = lsu_bready;
        if (m_bvalid && lsu_bready) begin
          state_next = IDLE;
        end else begin
          state_next = WR_LSU;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_ysyx_23060240_axi_rr_arb.sv
module tb_ysyx_23060240_axi_rr_arb;

  logic        clk;
  logic        rst;
  logic [31:0] ifu_araddr;
  logic        ifu_arvalid;
  logic        ifu_arready;
  logic [31:0] ifu_rdata;
  logic        ifu_rvalid;
  logic        ifu_rready;
  logic [31:0] lsu_araddr;
  logic        lsu_arvalid;
  logic        lsu_arready;
  logic [31:0] lsu_rdata;
  logic        lsu_rvalid;
  logic        lsu_rready;
  logic [31:0] lsu_awaddr;
  logic        lsu_awvalid;
  logic        lsu_awready;
  logic [31:0] lsu_wdata;
  logic [3:0]  lsu_wstrb;
  logic        lsu_wvalid;
  logic        lsu_wready;
  logic        lsu_bvalid;
  logic        lsu_bready;
  logic [31:0] m_araddr;
  logic        m_arvalid;
  logic        m_arready;
  logic [31:0] m_rdata;
  logic        m_rvalid;
  logic        m_rready;
  logic [31:0] m_awaddr;
  logic        m_awvalid;
  logic        m_awready;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;
  logic        m_wvalid;
  logic        m_wready;
  logic        m_bvalid;
  logic        m_bready;

  int tests_run = 0;
  int tests_failed = 0;

  localparam logic [31:0] IA = 32'h8000_0000;
  localparam logic [31:0] LA = 32'h0000_2000;

  ysyx_23060240_axi_rr_arb dut (
    .clk(clk), .rst(rst),
    .ifu_araddr(ifu_araddr), .ifu_arvalid(ifu_arvalid), .ifu_arready(ifu_arready),
    .ifu_rdata(ifu_rdata), .ifu_rvalid(ifu_rvalid), .ifu_rready(ifu_rready),
    .lsu_araddr(lsu_araddr), .lsu_arvalid(lsu_arvalid), .lsu_arready(lsu_arready),
    .lsu_rdata(lsu_rdata), .lsu_rvalid(lsu_rvalid), .lsu_rready(lsu_rready),
    .lsu_awaddr(lsu_awaddr), .lsu_awvalid(lsu_awvalid), .lsu_awready(lsu_awready),
    .lsu_wdata(lsu_wdata), .lsu_wstrb(lsu_wstrb), .lsu_wvalid(lsu_wvalid), .lsu_wready(lsu_wready),
    .lsu_bvalid(lsu_bvalid), .lsu_bready(lsu_bready),
    .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rvalid(m_rvalid), .m_rready(m_rready),
    .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bvalid(m_bvalid), .m_bready(m_bready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // in  = {ifu_arvalid, lsu_arvalid, lsu_awvalid, lsu_wvalid, m_arready, m_rvalid, m_awready, m_wready, m_bvalid}
  // exp = {m_arvalid, ifu_arready, ifu_rvalid, lsu_arready, lsu_rvalid, m_awvalid, m_wvalid,
  //        lsu_awready, lsu_wready, lsu_bvalid, m_rready, m_bready}
  typedef struct {
    logic [8:0]  in;
    logic [31:0] rdata;
    logic [11:0] exp;
    logic [31:0] e_araddr;
    logic [31:0] e_ifu_rd;
    logic [31:0] e_lsu_rd;
  } vec_t;

  vec_t vecs [19];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [11:0] obs();
    return {m_arvalid, ifu_arready, ifu_rvalid, lsu_arready, lsu_rvalid, m_awvalid, m_wvalid,
            lsu_awready, lsu_wready, lsu_bvalid, m_rready, m_bready};
  endfunction

  function automatic logic any_out();
    return |{ifu_arready, ifu_rdata, ifu_rvalid, lsu_arready, lsu_rdata, lsu_rvalid,
             lsu_awready, lsu_wready, lsu_bvalid, m_araddr, m_arvalid, m_rready,
             m_awaddr, m_awvalid, m_wdata, m_wstrb, m_wvalid, m_bready};
  endfunction

  task automatic drive(input logic [8:0] in, input logic [31:0] rdata);
    {ifu_arvalid, lsu_arvalid, lsu_awvalid, lsu_wvalid, m_arready, m_rvalid,
     m_awready, m_wready, m_bvalid} = in;
    m_rdata = rdata;
  endtask

  initial begin
    // IFU alone, then contention alternating, LSU read before write, W before AW
    vecs[0]  = '{9'b100000000, 32'h0,        12'b000000000000, 32'h0, 32'h0,        32'h0};
    vecs[1]  = '{9'b100010000, 32'h0,        12'b110000000010, IA,    32'h0,        32'h0};
    vecs[2]  = '{9'b000001000, 32'h00000413, 12'b001000000010, IA,    32'h00000413, 32'h0};
    vecs[3]  = '{9'b110000000, 32'h0,        12'b000000000000, 32'h0, 32'h0,        32'h0};
    vecs[4]  = '{9'b110010000, 32'h0,        12'b100100000010, LA,    32'h0,        32'h0};
    vecs[5]  = '{9'b110001000, 32'h12345678, 12'b100010000010, LA,    32'h0,        32'h12345678};
    vecs[6]  = '{9'b110000000, 32'h0,        12'b000000000000, 32'h0, 32'h0,        32'h0};
    vecs[7]  = '{9'b110000000, 32'h0,        12'b100000000010, IA,    32'h0,        32'h0};
    vecs[8]  = '{9'b110001000, 32'hdeadbeef, 12'b101000000010, IA,    32'hdeadbeef, 32'h0};
    vecs[9]  = '{9'b011000001, 32'h00000099, 12'b000000000000, 32'h0, 32'h0,        32'h0};
    vecs[10] = '{9'b011010100, 32'h0,        12'b100100000010, LA,    32'h0,        32'h0};
    vecs[11] = '{9'b001001000, 32'h00000055, 12'b000010000010, LA,    32'h0,        32'h00000055};
    vecs[12] = '{9'b000100000, 32'h0,        12'b000000000000, 32'h0, 32'h0,        32'h0};
    vecs[13] = '{9'b000100110, 32'h0,        12'b000000111001, 32'h0, 32'h0,        32'h0};
    vecs[14] = '{9'b101001110, 32'h00000077, 12'b000001010001, 32'h0, 32'h0,        32'h0};
    vecs[15] = '{9'b100000000, 32'h0,        12'b000000000001, 32'h0, 32'h0,        32'h0};
    vecs[16] = '{9'b100000001, 32'h0,        12'b000000000101, 32'h0, 32'h0,        32'h0};
    vecs[17] = '{9'b100000000, 32'h0,        12'b000000000000, 32'h0, 32'h0,        32'h0};
    vecs[18] = '{9'b100010000, 32'h0,        12'b110000000010, IA,    32'h0,        32'h0};

    rst = 1'b0;
    ifu_araddr = IA;
    lsu_araddr = LA;
    lsu_awaddr = 32'ha000_03f8;
    lsu_wdata  = 32'h0000_0041;
    lsu_wstrb  = 4'b0001;
    ifu_rready = 1'b1;
    lsu_rready = 1'b1;
    lsu_bready = 1'b1;
    drive(9'b110001001, 32'h1111_2222);

    // reset state: traffic present, all outputs held at zero
    repeat (2) @(negedge clk);
    #1;
    check("reset_outputs_zero", {127'h0, any_out()}, 128'h0);
    @(negedge clk);
    drive(9'b000000000, 32'h0);
    rst = 1'b1;

    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      drive(vecs[i].in, vecs[i].rdata);
      #1;
      check($sformatf("vec%0d", i),
            {20'h0, obs(), m_araddr, ifu_rdata, lsu_rdata},
            {20'h0, vecs[i].exp, vecs[i].e_araddr, vecs[i].e_ifu_rd, vecs[i].e_lsu_rd});
    end

    // slave stalls R for 20 cycles: IFU keeps the grant, LSU gets no arready
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      drive(9'b010010000, 32'h0);
      #1;
      check($sformatf("stall%0d", k), {95'h0, lsu_arready, m_rready, m_araddr}, {95'h0, 1'b0, 1'b1, IA});
    end
    @(negedge clk);
    drive(9'b010011000, 32'h0000_0013);
    #1;
    check("stall_release", {95'h0, ifu_rvalid, lsu_rvalid, ifu_rdata}, {95'h0, 1'b1, 1'b0, 32'h0000_0013});
    @(negedge clk);
    drive(9'b010010000, 32'h0);
    #1;
    check("gap_idle", {126'h0, lsu_arready, m_arvalid}, 128'h0);
    @(negedge clk);
    #1;
    check("lsu_after_stall", {95'h0, lsu_arready, m_arvalid, m_araddr}, {95'h0, 1'b1, 1'b1, LA});
    @(negedge clk);
    drive(9'b000001000, 32'h0);
    @(negedge clk);
    drive(9'b000000000, 32'h0);

    // LSU write with AW and W together, then reset after the AW handshake
    @(negedge clk);
    drive(9'b001100100, 32'h0);
    @(negedge clk);
    #1;
    check("wr_fields", {59'h0, m_awvalid, m_wvalid, m_awaddr, m_wdata, m_wstrb},
          {59'h0, 1'b1, 1'b1, 32'ha000_03f8, 32'h0000_0041, 4'b0001});
    @(negedge clk);
    drive(9'b000100100, 32'h0);
    #1;
    check("wr_after_aw", {125'h0, m_awvalid, m_wvalid, lsu_awready}, {125'h0, 1'b0, 1'b1, 1'b0});
    #2;
    rst = 1'b0;
    #1;
    check("mid_wr_reset", {127'h0, any_out()}, 128'h0);
    @(negedge clk);
    rst = 1'b1;
    drive(9'b001100000, 32'h0);
    @(negedge clk);
    #1;
    check("wr_flags_clear", {126'h0, m_awvalid, m_wvalid}, {126'h0, 1'b1, 1'b1});
    @(negedge clk);
    drive(9'b001100110, 32'h0);
    @(negedge clk);
    drive(9'b000000001, 32'h0);
    #1;
    check("wr_bresp", {125'h0, lsu_bvalid, m_awvalid, m_wvalid}, {125'h0, 1'b1, 1'b0, 1'b0});
    @(negedge clk);
    drive(9'b000000000, 32'h0);
    #1;
    check("wr_idle", {127'h0, m_bready}, 128'h0);

    // after reset both masters request: IFU must win
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    drive(9'b110000000, 32'h0);
    @(negedge clk);
    #1;
    check("reset_rr_ifu_first", {95'h0, m_arvalid, lsu_arready, m_araddr}, {95'h0, 1'b1, 1'b0, IA});
    drive(9'b000000000, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
